// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit:
// data width, reset value, size encodings, FSM state encodings and the
// byte-enable / misalignment helpers used by both the LSU and its aligner.
package mem_stage_lsu_pkg;

    localparam int          LENGTH         = 32;
    localparam logic [31:0] INITIAL_VAL_32 = 32'h0000_0000;

    // mem_size encodings; 2'b11 is illegal and handled as a word access
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_e;

    // Little-endian byte lanes touched by an access of the given size
    function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << lane;
            MEM_HALF: be = 4'b0011 << {lane[1], 1'b0};
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Bytes are never misaligned; halves need addr[0]=0; words need addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = lane[0];
            default:  mis = |lane;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed byte/half/word from a
// bus read word and sign- or zero-extends it to DATA_W. Kept free of LSU
// state so an instruction-side path can reuse it.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W = LENGTH
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the lane and extend according to size and signedness
    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_BYTE: data = {{(DATA_W-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
            MEM_HALF: data = {{(DATA_W-16){half_sel[15] & ~is_unsigned}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Issues one single-beat bus request per
// aligned access, stalls the pipeline while it is outstanding and then
// opens a one-cycle DONE window in which MEM/WB captures load_data.
// Optional build macro: LSU_TIMEOUT_EN (bus-ack timeout with bus_err pulse).
//
// Bus handshake: bus_req rises on the edge leaving IDLE and holds, with
// bus_we/addr/be/wdata stable, until the edge on which bus_ack is seen in
// ACCESS (bus_ack may already be high in the first ACCESS cycle). bus_ack
// is a one-cycle strobe qualifying bus_rdata; it is ignored outside ACCESS.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W         = LENGTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    lsu_state_e        state_q, state_d;
    logic              acc;
    logic              misaligned;
    logic              timeout;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic              uns_q;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] store_lanes;

    assign acc        = mem_read | mem_write;
    assign misaligned = is_misaligned(mem_size, addr[1:0]);

    // Replicate store data across every lane it may land in
    always_comb begin
        case (mem_size)
            MEM_BYTE: store_lanes = {4{store_data[7:0]}};
            MEM_HALF: store_lanes = {2{store_data[15:0]}};
            default:  store_lanes = store_data;
        endcase
    end

    // Size/lane/sign are captured at issue so extraction does not depend
    // on the frozen pipeline inputs staying put
    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata       (bus_rdata),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .data        (aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Fires on the edge that would complete TIMEOUT_CYCLES waiting cycles;
    // a simultaneous ack takes priority
    assign timeout = (state_q == LSU_ACCESS) && !bus_ack && (cnt_q == CNT_LAST);

    // ACCESS-cycle counter, zero whenever not waiting on the bus
    always_ff @(posedge clk) begin
        if (rst || state_q != LSU_ACCESS) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One-cycle error pulse on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign bus_err            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:   if (acc && !misaligned) state_d = LSU_ACCESS;
            LSU_ACCESS: if (bus_ack || timeout) state_d = LSU_DONE;
            LSU_DONE:   state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    // FSM outputs: stall covers the request cycle and every waiting cycle
    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                misalign = acc & misaligned;
                stall    = acc & ~misaligned;
            end
            LSU_ACCESS: stall = 1'b1;
            default: ;
        endcase
    end

    // Registered bus outputs and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data <= INITIAL_VAL_32;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            size_q    <= MEM_BYTE;
            lane_q    <= 2'b00;
            uns_q     <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (acc && misaligned) begin
                        load_data <= '0;
                    end else if (acc) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[DATA_W-1:2], 2'b00};
                        bus_be    <= lane_enables(mem_size, addr[1:0]);
                        bus_wdata <= mem_write ? store_lanes : '0;
                        size_q    <= mem_size;
                        lane_q    <= addr[1:0];
                        uns_q     <= mem_unsigned;
                    end
                end
                LSU_ACCESS: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        load_data <= bus_we ? '0 : aligned;
                    end else if (timeout) begin
                        bus_req   <= 1'b0;
                        load_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit of the MEM stage. It issues single-beat requests to the data-memory bus and produces the aligned, extended load value that the MEM/WB pipeline register captures. While a bus access is outstanding it stalls the pipeline, so load data is valid exactly in the cycle the pipeline advances.

Parameters:
DATA_W, 32, data and address width; equals `LENGTH from head.v
TIMEOUT_CYCLES, 255, bus-ack wait limit; used only with LSU_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_read  in  1  EX/MEM load request
mem_write  in  1  EX/MEM store request
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
addr  in  DATA_W  byte address (ALU result)
store_data  in  DATA_W  rt value to store
load_data  out  DATA_W  aligned load result, to MEM/WB Read_memory_data_in
stall  out  1  freeze IF..EX/MEM registers (combinational)
misalign  out  1  misaligned access flagged (combinational)
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write
bus_addr  out  DATA_W  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  byte enables, little-endian lanes
bus_wdata  out  DATA_W  lane-replicated store data
bus_ack  in  1  one-cycle completion strobe
bus_rdata  in  DATA_W  read data, valid with bus_ack
bus_err  out  1  timeout pulse; tied 0 without LSU_TIMEOUT_EN

Behaviour:
- Reset: FSM to IDLE. load_data, bus_req, bus_we, bus_addr, bus_be, bus_wdata and bus_err all clear to 0. All bus outputs and load_data are registered.
- Access condition: acc = mem_read | mem_write. If both are high, the access is treated as a store.
- Misalignment: half with addr[0]=1; word/illegal with addr[1:0]!=0. Byte accesses are never misaligned.
  - misalign = IDLE & acc & misaligned.
  - No bus transaction is issued, stall=0, and load_data is cleared to 0 at the next edge.
- IDLE:
  - On acc & !misaligned: register bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata, then go to ACCESS.
  - stall=1 in this cycle.
- ACCESS:
  - stall=1. Bus outputs are held stable.
  - On bus_ack: bus_req<=0. On a load, load_data<=extract(bus_rdata); on a store, load_data<=0. Go to DONE.
  - An ack arriving in the same cycle req first appears is legal. Ack outside ACCESS is ignored.
- DONE:
  - stall=0 for exactly one cycle, so the pipeline advances and MEM/WB captures load_data. Then go to IDLE.
  - The held acc is not reissued. Back-to-back accesses therefore take at least 3 cycles each.
- Latency: request cycle + N wait cycles + DONE. Minimum 3 cycles with an immediate ack.
- Extraction (lane = addr[1:0]):
  - byte: bus_rdata[8*lane+7 : 8*lane], sign/zero extended.
  - half: bus_rdata[16*addr[1]+15 : 16*addr[1]], sign/zero extended.
  - word: unchanged.
- Store lanes:
  - byte: be=4'b0001<<lane, wdata={4{sd[7:0]}}.
  - half: be=4'b0011<<(2*addr[1]), wdata={2{sd[15:0]}}.
  - word: be=4'b1111, wdata=sd.
  - For loads, be is set per size the same way and bus_wdata=0.
- Reset mid-access: FSM to IDLE and bus_req=0 on the same edge. The bus agent must tolerate the abandoned request.
- No acc in IDLE: stall=0, outputs hold.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8+ bit counter (width clog2(TIMEOUT_CYCLES+1)) runs in ACCESS and clears on entry.
- When the count reaches TIMEOUT_CYCLES with no ack: bus_req<=0, bus_err<=1 for one cycle, load_data<=0, go to DONE.
- An ack in the same cycle as the timeout wins, and bus_err stays 0.
- Undefined: no counter, bus_err tied 0, and ACCESS waits indefinitely.

Decomposition:
- head.v gets the shared constants:
  - `LENGTH and `INITIAL_VAL_32 (reused).
  - Size encodings `MEM_BYTE/`MEM_HALF/`MEM_WORD.
  - FSM state encodings `LSU_IDLE/`LSU_ACCESS/`LSU_DONE.
- One sub-module, lsu_load_align: combinational extract and extend of bus_rdata by size, lane and unsigned. It is reusable for a future instruction-side path.

Test Plan:
- Reset then idle: rst=1 two cycles -> all outputs 0, stall=0; with acc=0 afterwards, bus_req stays 0.
- lb, addr=0x1003, rdata=0x80FF_1234, ack on the 2nd ACCESS cycle -> bus_addr=0x1000, be=1000, stall high for 3 cycles, load_data=0xFFFF_FF80 in DONE; with lbu -> 0x0000_0080.
- sh, addr=0x2002, store_data=0xDEAD_BEEF, immediate ack -> bus_we=1, be=1100, wdata=0xBEEF_BEEF, stall exactly 2 cycles, then one DONE cycle.
- lw, addr=0x0006 -> misalign=1, stall=0, bus_req never asserted, load_data=0 next cycle.
- rst asserted during ACCESS with ack withheld -> next edge IDLE, bus_req=0, stall=0; a late ack is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, lw with no ack -> bus_err pulses once after 4 ACCESS cycles, load_data=0, DONE follows.
